// File: rtl/serial_collector.sv
// Serial-to-parallel receive stage for an LSB-first shifter stream.
// Each word goes out through a valid/ready register, with a frame counter and a sticky overrun flag.
module serial_collector #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             start,
  output logic [SIZE-1:0]  dout,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_r;
  logic [BW-1:0]    bit_cnt_r;
  logic [SIZE-1:0]  shreg_r;
  logic [SIZE-1:0]  dout_r;
  logic             valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic [CNT_W-1:0] frame_cnt_r;

  logic [SIZE-1:0]  word_s;
  logic             done_s;
  logic             drop_s;

  // Word being assembled this edge, completion and drop decisions.
  always_comb begin
    word_s = {sin, shreg_r[SIZE-1:1]};
    if ((state_r == RECV) && (bit_cnt_r == LAST_BIT)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
    drop_s = done_s && valid_r && !ready;
  end

  // Receive FSM plus the output register, handshake, counter and overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= '0;
      shreg_r     <= '0;
      dout_r      <= '0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= RECV;
            bit_cnt_r <= '0;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        RECV: begin
          if (done_s) begin
            // A start on the completing edge chains straight into the next frame.
            shreg_r   <= word_s;
            bit_cnt_r <= '0;
            state_r   <= start ? RECV : IDLE;
            busy_r    <= start;
          end else if (start) begin
            bit_cnt_r <= '0;
            shreg_r   <= '0;
            busy_r    <= 1'b1;
          end else begin
            shreg_r   <= word_s;
            bit_cnt_r <= bit_cnt_r + BW'(1);
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= '0;
          busy_r    <= 1'b0;
        end
      endcase

      if (done_s && !drop_s) begin
        dout_r      <= word_s;
        valid_r     <= 1'b1;
        frame_cnt_r <= frame_cnt_r + CNT_W'(1);
      end else if (valid_r && ready) begin
        valid_r     <= 1'b0;
      end

      // A drop on the same edge as a clear must still leave the flag set.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (clr_ovr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign dout      = dout_r;
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_serial_collector.sv
// Self-checking bench for serial_collector: directed scenarios plus random traffic against a bit-list model.
// Two instances share the stimulus: CNT_W=8 and CNT_W=2, so that counter wrap is exercised.
module tb_serial_collector;
  localparam int SIZE = 8;

  logic clk = 1'b0;
  logic rst_n, sin, start, ready, clr_ovr;
  logic [SIZE-1:0] dout, dout2;
  logic valid, valid2, busy, busy2, overrun, overrun2;
  logic [7:0] frame_cnt;
  logic [1:0] frame_cnt2;

  int checks = 0;
  int errors = 0;

  // Model: the bits of the frame in progress, plus what the consumer must see.
  bit              m_inframe;
  int              m_nbits;
  logic [SIZE-1:0] m_acc;
  logic [SIZE-1:0] m_dout;
  bit              m_valid, m_ovr;
  int              m_cnt;

  always #5 clk = ~clk;

  serial_collector #(.SIZE(SIZE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .start(start), .dout(dout), .valid(valid),
    .ready(ready), .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr), .frame_cnt(frame_cnt));

  serial_collector #(.SIZE(SIZE), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .start(start), .dout(dout2), .valid(valid2),
    .ready(ready), .busy(busy2), .overrun(overrun2), .clr_ovr(clr_ovr), .frame_cnt(frame_cnt2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inframe = 0; m_nbits = 0; m_acc = '0; m_dout = '0;
    m_valid = 0; m_ovr = 0; m_cnt = 0;
  endtask

  // Apply one clock edge to the model, using the inputs present at that edge.
  task automatic model_step();
    bit complete;
    bit drop;
    complete = 0;
    if (m_inframe) begin
      if (start && m_nbits < SIZE - 1) begin
        m_nbits = 0;
        m_acc = '0;
      end else begin
        m_acc[m_nbits] = sin;
        m_nbits++;
        if (m_nbits == SIZE) begin
          complete = 1;
          m_nbits = 0;
          m_inframe = start;
        end
      end
    end else if (start) begin
      m_inframe = 1;
      m_nbits = 0;
    end
    drop = complete && m_valid && !ready;
    if (complete && !drop) begin
      m_dout = m_acc;
      m_valid = 1;
      m_cnt++;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr_ovr) m_ovr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Shift out w LSB first. Optionally raise start on the last bit to chain the next frame.
  task automatic bits(input logic [SIZE-1:0] w, input bit chain);
    for (int i = 0; i < SIZE; i++) begin
      sin = w[i];
      start = chain && (i == SIZE - 1);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic strobe();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Compare process: every cycle out of reset, both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("dout", 32'(dout), 32'(m_dout));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_inframe));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt % 256));
      chk("dout2", 32'(dout2), 32'(m_dout));
      chk("valid2", 32'(valid2), 32'(m_valid));
      chk("overrun2", 32'(overrun2), 32'(m_ovr));
      chk("frame_cnt2", 32'(frame_cnt2), 32'(m_cnt % 4));
    end
  end

  initial begin
    rst_n = 1'b0; sin = 1'b0; start = 1'b0; ready = 1'b0; clr_ovr = 1'b0;
    model_reset();
    #3;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame: the word appears SIZE edges after the strobe.
    ready = 1'b1;
    strobe();
    bits(8'hA5, 1'b0);
    chk("single_dout", 32'(dout), 32'hA5);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_cnt", 32'(frame_cnt), 32'h1);
    chk("single_busy", 32'(busy), 32'h0);
    tick();
    chk("single_ack", 32'(valid), 32'h0);

    // Back-to-back frames with ready held high.
    strobe();
    bits(8'h3C, 1'b1);
    chk("b2b_0", 32'(dout), 32'h3C);
    chk("b2b_busy", 32'(busy), 32'h1);
    bits(8'hC3, 1'b1);
    chk("b2b_1", 32'(dout), 32'hC3);
    chk("b2b_valid", 32'(valid), 32'h1);
    chk("b2b_novr", 32'(overrun), 32'h0);
    bits(8'hFF, 1'b0);
    chk("b2b_2", 32'(dout), 32'hFF);
    chk("b2b_cnt", 32'(frame_cnt), 32'h4);
    chk("b2b_cnt2", 32'(frame_cnt2), 32'h0);
    tick();

    // Overrun: the second word is dropped while the first sits unaccepted.
    ready = 1'b0;
    strobe();
    bits(8'h11, 1'b0);
    strobe();
    bits(8'h22, 1'b0);
    chk("ovr_dout", 32'(dout), 32'h11);
    chk("ovr_flag", 32'(overrun), 32'h1);
    chk("ovr_cnt", 32'(frame_cnt), 32'h5);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);
    ready = 1'b1;
    tick();
    chk("ovr_ack", 32'(valid), 32'h0);

    // Abort: a second strobe three edges in restarts the frame.
    strobe();
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    strobe();
    bits(8'h5A, 1'b0);
    chk("abort_dout", 32'(dout), 32'h5A);
    chk("abort_cnt", 32'(frame_cnt), 32'h6);
    chk("abort_cnt2", 32'(frame_cnt2), 32'h2);
    tick();

    // Reset in the middle of a frame, then a clean frame after release.
    strobe();
    sin = 1'b1; tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_dout", 32'(dout), 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    strobe();
    bits(8'h81, 1'b0);
    chk("post_rst_dout", 32'(dout), 32'h81);
    chk("post_rst_cnt", 32'(frame_cnt), 32'h1);

    // Random traffic: sparse strobes so that completions, aborts and drops all occur.
    for (int n = 0; n < 4000; n++) begin
      sin = 1'($urandom);
      start = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 3) != 0);
      clr_ovr = ($urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b0;
    clr_ovr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
